// File: rtl/led_mode_scheduler.sv
// rtl/led_mode_scheduler.sv - debounced LED mode selection with step tick divider and clear sequencing
// Define AUTO_CYCLE_EN to add AutoMode-driven automatic mode cycling.
module led_mode_scheduler #(
  parameter int TICK_SLOW    = 50000000,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int DWELL_STEPS  = 16
) (
  input  logic       HWClock,
  input  logic       Reset,
  input  logic [3:0] Switch,
  input  logic       AutoMode,
  output logic [1:0] ModeSel,
  output logic       Fast,
  output logic       Reverse,
  output logic       StepTick,
  output logic       ModeClear
);

  localparam int DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;
  localparam int DIV_W = $clog2(TICK_SLOW);
  localparam logic [DIV_W-1:0] SLOW_LAST = DIV_W'(TICK_SLOW - 1);
  localparam logic [DIV_W-1:0] FAST_LAST = DIV_W'(TICK_SLOW / 2 - 1);

`ifdef AUTO_CYCLE_EN
  localparam int NDB  = 5;
  localparam int DW_W = $clog2(DWELL_STEPS + 1);
`else
  localparam int NDB  = 4;
`endif

  typedef enum logic [1:0] {ST_CLEAR, ST_MANUAL, ST_AUTO} state_t;

  logic [NDB-1:0]  raw;
  logic [NDB-1:0]  stable_q, stable_d;
  logic [DB_W-1:0] db_cnt_q [NDB];
  logic [DB_W-1:0] db_cnt_d [NDB];

  state_t           state_q, state_d;
  logic [1:0]       mode_sel_q, mode_sel_d;
  logic             fast_q, fast_d;
  logic             reverse_q, reverse_d;
  logic             tick_q, tick_d;
  logic             mode_clear_q, mode_clear_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] div_last;
  logic [1:0]       sw_mode;
  logic             auto_on;
  logic             load_sw;

`ifdef AUTO_CYCLE_EN
  logic [DW_W-1:0] dwell_q, dwell_d;
  assign raw     = {AutoMode, Switch};
  assign auto_on = stable_q[4];
`else
  logic unused_auto_mode;
  assign unused_auto_mode = AutoMode;
  assign raw     = Switch;
  assign auto_on = 1'b0;
`endif

  assign sw_mode = stable_q[1:0];

  // A differing raw sample extends the run; any agreeing sample restarts it.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NDB; i++) begin
      db_cnt_d[i] = '0;
      if (raw[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
          stable_d[i] = raw[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_sel_d = mode_sel_q;
    load_sw    = 1'b0;
`ifdef AUTO_CYCLE_EN
    dwell_d    = dwell_q;
`endif
    case (state_q)
      ST_CLEAR: begin
        // mode_clear_q low here only in the first cycle out of reset
        if (mode_clear_q) begin
          state_d = auto_on ? ST_AUTO : ST_MANUAL;
        end else begin
          load_sw = 1'b1;
        end
      end
      ST_MANUAL: begin
        if (sw_mode != mode_sel_q || auto_on) begin
          state_d = ST_CLEAR;
          load_sw = 1'b1;
        end
      end
`ifdef AUTO_CYCLE_EN
      ST_AUTO: begin
        if (!auto_on) begin
          state_d = ST_CLEAR;
          load_sw = 1'b1;
        end else if (tick_q && dwell_q == DW_W'(DWELL_STEPS - 1)) begin
          state_d    = ST_CLEAR;
          mode_sel_d = mode_sel_q + 1'b1;
        end
      end
`endif
      default: state_d = ST_CLEAR;
    endcase
    if (load_sw) begin
      mode_sel_d = sw_mode;
    end
`ifdef AUTO_CYCLE_EN
    if (state_q != ST_AUTO || state_d != ST_AUTO) begin
      dwell_d = '0;
    end else if (tick_q) begin
      dwell_d = dwell_q + 1'b1;
    end
`endif
  end

  always_comb begin
    mode_clear_d = (state_d == ST_CLEAR);
    fast_d       = stable_q[2];
    reverse_d    = stable_q[3];
    div_last     = fast_q ? FAST_LAST : SLOW_LAST;
    div_d        = div_q + 1'b1;
    tick_d       = 1'b0;
    // >= lets a switch to the shorter period wrap immediately.
    if (state_q == ST_CLEAR || state_d == ST_CLEAR) begin
      div_d = '0;
    end else if (div_q >= div_last) begin
      div_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge HWClock or posedge Reset) begin
    if (Reset) begin
      stable_q     <= '0;
      for (int i = 0; i < NDB; i++) db_cnt_q[i] <= '0;
      state_q      <= ST_CLEAR;
      mode_sel_q   <= 2'b00;
      fast_q       <= 1'b0;
      reverse_q    <= 1'b0;
      tick_q       <= 1'b0;
      mode_clear_q <= 1'b0;
      div_q        <= '0;
`ifdef AUTO_CYCLE_EN
      dwell_q      <= '0;
`endif
    end else begin
      stable_q     <= stable_d;
      for (int i = 0; i < NDB; i++) db_cnt_q[i] <= db_cnt_d[i];
      state_q      <= state_d;
      mode_sel_q   <= mode_sel_d;
      fast_q       <= fast_d;
      reverse_q    <= reverse_d;
      tick_q       <= tick_d;
      mode_clear_q <= mode_clear_d;
      div_q        <= div_d;
`ifdef AUTO_CYCLE_EN
      dwell_q      <= dwell_d;
`endif
    end
  end

  assign ModeSel   = mode_sel_q;
  assign Fast      = fast_q;
  assign Reverse   = reverse_q;
  assign StepTick  = tick_q;
  assign ModeClear = mode_clear_q;

endmodule

// File: tb/tb_led_mode_scheduler.sv
// tb/tb_led_mode_scheduler.sv - self-checking bench for led_mode_scheduler
module tb_led_mode_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw = 4'b0000;
  logic       auto_req = 1'b0;
  logic [1:0] mode_sel;
  logic       fast, reverse, step_tick, mode_clear;

  int tests = 0;
  int fails = 0;
  int mc_count = 0;
  int tick_count = 0;
  int overlap = 0;

  typedef struct {
    logic [3:0] sw;
    logic [1:0] mode;
    logic       fast;
    logic       rev;
    int         clears;
  } vec_t;

  vec_t vecs[6];

  led_mode_scheduler #(.TICK_SLOW(8), .DEBOUNCE_CYC(4), .DWELL_STEPS(2)) dut (
    .HWClock(clk), .Reset(rst), .Switch(sw), .AutoMode(auto_req),
    .ModeSel(mode_sel), .Fast(fast), .Reverse(reverse),
    .StepTick(step_tick), .ModeClear(mode_clear)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      mc_count   <= mc_count + int'(mode_clear);
      tick_count <= tick_count + int'(step_tick);
      if (step_tick && mode_clear) overlap <= overlap + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin step(); n++; end while (!step_tick && n < 100);
  endtask

  task automatic wait_mc(output int n);
    n = 0;
    do begin step(); n++; end while (!mode_clear && n < 100);
  endtask

  task automatic release_seq();
    int n;
    rst = 1'b0;
    step();
    check("release_mc_first", int'(mode_clear), 1);
    check("release_modesel", int'(mode_sel), 0);
    step();
    check("release_mc_one_cycle", int'(mode_clear), 0);
    wait_tick(n);
    check("release_first_tick", n, 8);
    wait_tick(n);
    check("release_tick_period", n, 8);
  endtask

  initial begin
    int n;
    int mc0;
    int t0;
    vecs[0] = '{4'b1101, 2'b01, 1'b1, 1'b1, 0};
    vecs[1] = '{4'b1110, 2'b10, 1'b1, 1'b1, 1};
    vecs[2] = '{4'b0011, 2'b11, 1'b0, 1'b0, 1};
    vecs[3] = '{4'b0111, 2'b11, 1'b1, 1'b0, 0};
    vecs[4] = '{4'b1000, 2'b00, 1'b0, 1'b1, 1};
    vecs[5] = '{4'b0000, 2'b00, 1'b0, 1'b0, 0};

    repeat (3) step();
    check("reset_outputs", int'({mode_sel, fast, reverse, step_tick, mode_clear}), 0);
    release_seq();

    mc0 = mc_count;
    sw = 4'b0001;
    repeat (3) step();
    sw = 4'b0000;
    step();
    sw = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      step();
      check("bounce_hold", int'({mode_sel, mode_clear}), 0);
    end
    step();
    check("bounce_accept", int'({mode_sel, mode_clear}), 3);
    repeat (20) step();
    check("bounce_single_clear", mc_count - mc0, 1);

    wait_tick(n);
    step();
    sw = 4'b0101;
    wait_tick(n);
    check("fast_early_tick", n, 6);
    check("fast_out", int'(fast), 1);
    wait_tick(n);
    check("fast_period_a", n, 4);
    wait_tick(n);
    check("fast_period_b", n, 4);

    for (int i = 0; i < 6; i++) begin
      mc0 = mc_count;
      sw = vecs[i].sw;
      repeat (12) step();
      check($sformatf("vec%0d_out", i), int'({mode_sel, fast, reverse}),
            int'({vecs[i].mode, vecs[i].fast, vecs[i].rev}));
      check($sformatf("vec%0d_clears", i), mc_count - mc0, vecs[i].clears);
    end

`ifdef AUTO_CYCLE_EN
    auto_req = 1'b1;
    wait_mc(n);
    check("auto_enter_latency", n, 5);
    check("auto_enter_mode", int'(mode_sel), 0);
    sw = 4'b0010;
    for (int i = 1; i <= 4; i++) begin
      t0 = tick_count;
      wait_mc(n);
      check($sformatf("auto_period%0d", i), n, 18);
      check($sformatf("auto_mode%0d", i), int'(mode_sel), i % 4);
      check($sformatf("auto_ticks%0d", i), tick_count - t0, 2);
    end
    repeat (13) step();
    auto_req = 1'b0;
    repeat (4) step();
    check("drop_no_early_clear", int'(mode_clear), 0);
    mc0 = mc_count;
    step();
    check("drop_clear_reload", int'({mode_sel, mode_clear}), 5);
    repeat (30) step();
    check("drop_single_clear", mc_count - mc0, 1);
    check("drop_manual_mode", int'(mode_sel), 2);
`else
    mc0 = mc_count;
    auto_req = 1'b1;
    repeat (30) step();
    check("auto_ignored_clears", mc_count - mc0, 0);
    check("auto_ignored_mode", int'(mode_sel), 0);
    auto_req = 1'b0;
    wait_tick(n);
    wait_tick(n);
    check("auto_ignored_period", n, 8);
`endif

    sw = 4'b1010;
    auto_req = 1'b1;
    repeat (15) step();
    check("pre_reset_state", int'({mode_sel, reverse}), 5);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_outputs", int'({mode_sel, fast, reverse, step_tick, mode_clear}), 0);
    sw = 4'b0000;
    auto_req = 1'b0;
    repeat (3) step();
    check("held_reset_outputs", int'({mode_sel, fast, reverse, step_tick, mode_clear}), 0);
    release_seq();

    check("no_tick_clear_overlap", overlap, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
